uart_receiver: RTL and testbench
================================

Name: uart_receiver

Overview:
- UART RX stage; the downstream peer of the transmitter.
- Consumes the serial line the transmitter drives: idle high, 1 start bit (0), DATAWIDTH data bits LSB first, 1 stop bit (1), no parity.
- Recovers each byte by mid-bit sampling, presents it on a parallel bus with a 1-cycle valid strobe, and flags framing errors.
- Sits between the pad/loopback line and the SoC's UART register/FIFO logic.

Parameters:
- DATAWIDTH, 8: data bits per frame.
- CLKS_PER_BIT, 10416: clk cycles per bit (100 MHz / 9600 baud). Must be >= 4. Sim benches use 16.

Ports:
- clk  input  1  system clock, all logic on rising edge
- i_reset_n  input  1  synchronous, active-low reset
- i_rx  input  1  asynchronous serial line (transmitter o_tx_data or pad)
- o_data  output  DATAWIDTH  last correctly framed byte, held until next good frame
- o_valid  output  1  one-cycle pulse: o_data updated this cycle
- o_frame_err  output  1  one-cycle pulse: stop bit sampled 0
- o_busy  output  1  high in every state except IDLE

Behaviour:
- Synchronizer:
  - i_rx passes through a 2-FF synchronizer (rx_s) before any use.
  - Both FFs reset to 1, so a low line during reset does not produce a false start.
- Reset (i_reset_n=0 at a clk edge):
  - state=IDLE, bit counter=0, clock counter=0, shift register=0.
  - o_data=0, o_valid=0, o_frame_err=0, o_busy=0.
  - Reset mid-frame abandons the frame with no pulse; after release the receiver waits for a fresh 1->0 transition.
- Clock counter: width $clog2(CLKS_PER_BIT); cleared on every state change.
- IDLE:
  - Enter START on rx_s 1->0 (previous sampled 1, current 0); the clock counter starts at 0.
  - A line already low when entering IDLE does not start a frame.
- START:
  - At clock counter == CLKS_PER_BIT/2-1 (integer divide), sample rx_s.
  - If 0, go to DATA; bit index=0.
  - If 1, treat as a glitch and return to IDLE with no pulse.
- DATA:
  - At clock counter == CLKS_PER_BIT-1, shift rx_s into shift reg MSB (LSB-first assembly) and increment the bit index.
  - After the DATAWIDTH-th sample, go to STOP.
- STOP: at clock counter == CLKS_PER_BIT-1, sample rx_s.
  - 1: next cycle o_data<=shift reg, o_valid=1 for exactly one cycle; return to IDLE (mid stop bit, so a back-to-back start edge is caught).
  - 0: next cycle o_frame_err=1 for one cycle, o_data unchanged; go to WAIT_HIGH.
- WAIT_HIGH: remain until rx_s==1, then IDLE. Handles break conditions; no further pulses.
- Pulse rules:
  - o_valid and o_frame_err are never high together.
  - Each is never high for 2 consecutive cycles.
- Latency: o_valid rises 2 + CLKS_PER_BIT/2 + (DATAWIDTH+1)*CLKS_PER_BIT + 1 cycles (±1) after the i_rx falling edge.
- Rate tolerance: sender bit period within ±2% of CLKS_PER_BIT is received correctly.
- No flow control: a new byte overwrites o_data; the consumer must capture on o_valid.

Test Plan:
- Reset: hold i_reset_n=0 with i_rx=0 for 20 cycles, then release with i_rx=1 -> all outputs 0, o_busy stays 0, no pulse.
- Single frame: CLKS_PER_BIT=16, drive 8'b0011_0011 -> exactly one o_valid pulse at 2+8+9*16+1 cycles (±1) after the start edge, with o_data=8'h33; o_frame_err never high.
- Back-to-back: drive 8'hAA, then 8'h0F, then 8'h00 with no idle gap, also through the transmitter via loopback -> three o_valid pulses carrying 8'hAA, 8'h0F, 8'h00 in order.
- Glitch: drive i_rx low for 3 cycles (< CLKS_PER_BIT/2), then high -> o_busy returns to 0 and no pulse occurs.
- Framing/break: send 8'h55 with stop bit 0 and hold the line low for 40 cycles -> one o_frame_err pulse, o_data keeps its previous value, o_busy high until the line goes high; then 8'hC3 is received correctly.
- Mid-frame reset: assert i_reset_n=0 during data bit 4 of 8'hFF, release before the frame ends -> no pulse for that frame, o_data=0, and the next frame 8'h81 is received correctly.

Source files
------------

// File: rtl/uart_receiver.sv
// UART receive stage: 8N1-style framing, mid-bit sampling, one-cycle valid and
// framing-error strobes on a registered parallel bus.
module uart_receiver #(
  parameter int DATAWIDTH    = 8,
  parameter int CLKS_PER_BIT = 10416
) (
  input  logic                 clk,
  input  logic                 i_reset_n,
  input  logic                 i_rx,
  output logic [DATAWIDTH-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_frame_err,
  output logic                 o_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATAWIDTH + 1);
  localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATAWIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } state_t;

  state_t               state_r, state_nxt_s;
  logic [CW-1:0]        clk_cnt_r, clk_cnt_nxt_s;
  logic [BW-1:0]        bit_idx_r, bit_idx_nxt_s;
  logic [DATAWIDTH-1:0] shift_r, shift_nxt_s;
  logic [DATAWIDTH-1:0] data_r, data_nxt_s;
  logic                 valid_r, valid_nxt_s;
  logic                 ferr_r, ferr_nxt_s;
  logic                 busy_r;
  logic                 rx_meta_r, rx_sync_r, rx_prev_r;
  logic                 rx_s;

  assign rx_s = rx_sync_r;

  // Two-flop synchronizer plus previous-sample flop; all idle-high out of reset.
  always_ff @(posedge clk) begin
    if (!i_reset_n) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= i_rx;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
    end
  end

  // Next-state and datapath decode.
  always_comb begin
    state_nxt_s   = state_r;
    bit_idx_nxt_s = bit_idx_r;
    shift_nxt_s   = shift_r;
    data_nxt_s    = data_r;
    valid_nxt_s   = 1'b0;
    ferr_nxt_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (rx_prev_r && !rx_s) state_nxt_s = ST_START;
        else                    state_nxt_s = ST_IDLE;
      end
      ST_START: begin
        if (clk_cnt_r == HALF_CNT) begin
          if (!rx_s) begin
            state_nxt_s   = ST_DATA;
            bit_idx_nxt_s = {BW{1'b0}};
          end else begin
            state_nxt_s   = ST_IDLE;
          end
        end else begin
          state_nxt_s = ST_START;
        end
      end
      ST_DATA: begin
        if (clk_cnt_r == FULL_CNT) begin
          shift_nxt_s   = {rx_s, shift_r[DATAWIDTH-1:1]};
          bit_idx_nxt_s = bit_idx_r + BW'(1);
          if (bit_idx_r == LAST_BIT) state_nxt_s = ST_STOP;
          else                       state_nxt_s = ST_DATA;
        end else begin
          state_nxt_s = ST_DATA;
        end
      end
      ST_STOP: begin
        // Leaving mid stop bit lets a back-to-back start edge be caught.
        if (clk_cnt_r == FULL_CNT) begin
          if (rx_s) begin
            data_nxt_s  = shift_r;
            valid_nxt_s = 1'b1;
            state_nxt_s = ST_IDLE;
          end else begin
            ferr_nxt_s  = 1'b1;
            state_nxt_s = ST_WAIT_HIGH;
          end
        end else begin
          state_nxt_s = ST_STOP;
        end
      end
      ST_WAIT_HIGH: begin
        if (rx_s) state_nxt_s = ST_IDLE;
        else      state_nxt_s = ST_WAIT_HIGH;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase

    if ((state_nxt_s != state_r) || (state_r == ST_IDLE) || (state_r == ST_WAIT_HIGH)) begin
      clk_cnt_nxt_s = {CW{1'b0}};
    end else begin
      clk_cnt_nxt_s = clk_cnt_r + CW'(1);
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!i_reset_n) begin
      state_r   <= ST_IDLE;
      clk_cnt_r <= {CW{1'b0}};
      bit_idx_r <= {BW{1'b0}};
      shift_r   <= {DATAWIDTH{1'b0}};
      data_r    <= {DATAWIDTH{1'b0}};
      valid_r   <= 1'b0;
      ferr_r    <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      clk_cnt_r <= clk_cnt_nxt_s;
      bit_idx_r <= bit_idx_nxt_s;
      shift_r   <= shift_nxt_s;
      data_r    <= data_nxt_s;
      valid_r   <= valid_nxt_s;
      ferr_r    <= ferr_nxt_s;
      busy_r    <= (state_nxt_s != ST_IDLE);
    end
  end

  assign o_data      = data_r;
  assign o_valid     = valid_r;
  assign o_frame_err = ferr_r;
  assign o_busy      = busy_r;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 16 clocks per bit: table-driven frames
// plus hand-written reset, back-to-back, glitch and mid-frame reset sequences.
module tb_uart_receiver;

  localparam int DW  = 8;
  localparam int CPB = 16;
  localparam int LAT = 2 + CPB / 2 + (DW + 1) * CPB + 1;

  logic          clk = 1'b0;
  logic          i_reset_n = 1'b0;
  logic          i_rx = 1'b0;
  logic [DW-1:0] o_data;
  logic          o_valid;
  logic          o_frame_err;
  logic          o_busy;

  uart_receiver #(.DATAWIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
    .clk         (clk),
    .i_reset_n   (i_reset_n),
    .i_rx        (i_rx),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_frame_err (o_frame_err),
    .o_busy      (o_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] vq[$];
  int   vcyc = 0;
  int   ferr_cnt = 0;
  int   viol = 0;
  logic prev_v = 1'b0;
  logic prev_f = 1'b0;

  // Pulse monitor: records received bytes, error pulses and pulse-rule violations.
  always @(negedge clk) begin
    if (o_valid === 1'b1) begin
      vq.push_back(o_data);
      vcyc = cyc;
    end
    if (o_frame_err === 1'b1) ferr_cnt++;
    if ((o_valid === 1'b1 && o_frame_err === 1'b1) ||
        (o_valid === 1'b1 && prev_v) || (o_frame_err === 1'b1 && prev_f)) viol++;
    prev_v = (o_valid === 1'b1);
    prev_f = (o_frame_err === 1'b1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b, input int n);
    i_rx = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0, CPB);
    for (int i = 0; i < DW; i++) send_bit(d[i], CPB);
    send_bit(stop, CPB);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         low_hold;
    int         exp_valid;
    int         exp_ferr;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int n0, f0, t0, lat;

    vecs[0] = '{data: 8'h33, stop: 1'b1, low_hold: 0,  exp_valid: 1, exp_ferr: 0, exp_data: 8'h33};
    vecs[1] = '{data: 8'h55, stop: 1'b0, low_hold: 40, exp_valid: 0, exp_ferr: 1, exp_data: 8'h33};
    vecs[2] = '{data: 8'hC3, stop: 1'b1, low_hold: 0,  exp_valid: 1, exp_ferr: 0, exp_data: 8'hC3};
    vecs[3] = '{data: 8'h5A, stop: 1'b1, low_hold: 0,  exp_valid: 1, exp_ferr: 0, exp_data: 8'h5A};
    vecs[4] = '{data: 8'hFF, stop: 1'b1, low_hold: 0,  exp_valid: 1, exp_ferr: 0, exp_data: 8'hFF};

    // Reset held with the line low, then released with the line high.
    @(negedge clk);
    i_reset_n = 1'b0;
    i_rx      = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    check("rst_data",  o_data, 0);
    check("rst_valid", o_valid, 0);
    check("rst_ferr",  o_frame_err, 0);
    check("rst_busy",  o_busy, 0);
    i_reset_n = 1'b1;
    i_rx      = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    check("post_rst_busy",   o_busy, 0);
    check("post_rst_pulses", vq.size() + ferr_cnt, 0);
    check("post_rst_data",   o_data, 0);

    // Table of isolated frames.
    for (int k = 0; k < 5; k++) begin
      n0 = vq.size();
      f0 = ferr_cnt;
      t0 = cyc;
      send_frame(vecs[k].data, vecs[k].stop);
      if (vecs[k].low_hold > 0) begin
        send_bit(1'b0, vecs[k].low_hold);
        #1;
        check($sformatf("v%0d_busy_break", k), o_busy, 1);
      end
      send_bit(1'b1, 24);
      #1;
      check($sformatf("v%0d_valid_cnt", k), vq.size() - n0, vecs[k].exp_valid);
      check($sformatf("v%0d_ferr_cnt", k), ferr_cnt - f0, vecs[k].exp_ferr);
      check($sformatf("v%0d_data", k), o_data, vecs[k].exp_data);
      check($sformatf("v%0d_busy_idle", k), o_busy, 0);
      if (vecs[k].exp_valid == 1) begin
        lat = vcyc - t0;
        check($sformatf("v%0d_latency_%0d", k, lat), (lat >= LAT - 1 && lat <= LAT + 1), 1);
      end
    end

    // Reset during data bit 4 of 8'hFF, then a clean 8'h81.
    n0 = vq.size();
    f0 = ferr_cnt;
    send_bit(1'b0, CPB);
    send_bit(1'b1, 4 * CPB + 8);
    #1;
    check("mid_busy_before_rst", o_busy, 1);
    i_reset_n = 1'b0;
    send_bit(1'b1, 2);
    i_reset_n = 1'b1;
    send_bit(1'b1, 4 * CPB - 10 + CPB + 24);
    #1;
    check("mid_no_valid", vq.size() - n0, 0);
    check("mid_no_ferr",  ferr_cnt - f0, 0);
    check("mid_data_clr", o_data, 0);
    check("mid_busy",     o_busy, 0);
    send_frame(8'h81, 1'b1);
    send_bit(1'b1, 24);
    #1;
    check("mid_next_cnt",  vq.size() - n0, 1);
    check("mid_next_data", o_data, 8'h81);

    // Back-to-back frames with no idle gap.
    n0 = vq.size();
    f0 = ferr_cnt;
    send_frame(8'hAA, 1'b1);
    send_frame(8'h0F, 1'b1);
    send_frame(8'h00, 1'b1);
    send_bit(1'b1, 24);
    #1;
    check("b2b_cnt",  vq.size() - n0, 3);
    check("b2b_ferr", ferr_cnt - f0, 0);
    if (vq.size() >= n0 + 3) begin
      check("b2b_0", vq[n0],     8'hAA);
      check("b2b_1", vq[n0 + 1], 8'h0F);
      check("b2b_2", vq[n0 + 2], 8'h00);
    end

    // Short low glitch: starts a frame, then is rejected at the half-bit sample.
    n0 = vq.size();
    f0 = ferr_cnt;
    send_bit(1'b0, 3);
    send_bit(1'b1, 3);
    #1;
    check("glitch_busy_hi", o_busy, 1);
    send_bit(1'b1, 20);
    #1;
    check("glitch_busy_lo", o_busy, 0);
    check("glitch_no_pulse", (vq.size() - n0) + (ferr_cnt - f0), 0);
    check("glitch_data", o_data, 8'h00);

    check("pulse_rules", viol, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
